// File: rtl/neuron_integrator.sv
// ---------------------------------------------------------------------------
// neuron_integrator
//
// Leaky integrate-and-fire neuron. Each tick starts on tick_start, accepts a
// stream of signed 8-bit synapse values over a valid/ready handshake until
// syn_last, then applies one leak step and decides whether to fire.
//
// Ports
//    clk         in   sole clock, rising edge
//    rst         in   asynchronous, active-low reset
//    tick_start  in   begin a tick (honoured only in IDLE)
//    synapse_in  in   [7:0] two's-complement synapse value
//    syn_valid   in   synapse_in valid
//    syn_last    in   with syn_valid, final synapse of the tick
//    syn_ready   out  high only while integrating
//    spike       out  one-cycle pulse, neuron fired this tick
//    tick_done   out  one-cycle pulse, tick complete
//    potential   out  [POT_WIDTH-1:0] signed membrane potential
//
// Build option
//    REFRACTORY_EN  when defined, REFRACTORY_TICKS ticks after a spike accept
//                   synapses but hold the potential and cannot fire.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | waiting for tick_start
// ST_INTEGRATE | syn_ready high, accumulating synapses until syn_last
// ST_LEAK      | subtract LEAK (saturating), clamp to FLOOR
// ST_FIRE      | compare against THRESHOLD, pulse spike / tick_done
// ---------------------------------------------------------------------------
module neuron_integrator #(
   parameter int                          POT_WIDTH        = 16,
   parameter logic signed [POT_WIDTH-1:0] THRESHOLD        = 16'sd10,
   parameter logic signed [POT_WIDTH-1:0] LEAK             = 16'sd1,
   parameter logic signed [POT_WIDTH-1:0] RESET_POTENTIAL  = 16'sd0,
   parameter logic signed [POT_WIDTH-1:0] FLOOR            = -16'sd16,
   parameter int                          REFRACTORY_TICKS = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tick_start,
   input  logic [7:0]                  synapse_in,
   input  logic                        syn_valid,
   input  logic                        syn_last,
   output logic                        syn_ready,
   output logic                        spike,
   output logic                        tick_done,
   output logic signed [POT_WIDTH-1:0] potential
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_INTEGRATE = 2'd1,
      ST_LEAK      = 2'd2,
      ST_FIRE      = 2'd3
   } state_t;

   localparam logic signed [POT_WIDTH-1:0] POT_MAX = {1'b0, {(POT_WIDTH-1){1'b1}}};
   localparam logic signed [POT_WIDTH-1:0] POT_MIN = {1'b1, {(POT_WIDTH-1){1'b0}}};

   state_t                      state;
   logic                        refr_active;
   logic signed [POT_WIDTH:0]   add_ext;
   logic signed [POT_WIDTH:0]   sub_ext;
   logic signed [POT_WIDTH-1:0] add_sat;
   logic signed [POT_WIDTH-1:0] leak_sat;
   logic signed [POT_WIDTH-1:0] leak_val;

   // One guard bit: the two top bits disagree exactly when the result
   // left the signed POT_WIDTH range.
   function automatic logic signed [POT_WIDTH-1:0] sat(input logic signed [POT_WIDTH:0] v);
      if (v[POT_WIDTH] != v[POT_WIDTH-1])
         return v[POT_WIDTH] ? POT_MIN : POT_MAX;
      return v[POT_WIDTH-1:0];
   endfunction

   always_comb begin
      add_ext  = {potential[POT_WIDTH-1], potential}
               + {{(POT_WIDTH-7){synapse_in[7]}}, synapse_in};
      sub_ext  = {potential[POT_WIDTH-1], potential} - {LEAK[POT_WIDTH-1], LEAK};
      add_sat  = sat(add_ext);
      leak_sat = sat(sub_ext);
      leak_val = (leak_sat < FLOOR) ? FLOOR : leak_sat;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         potential <= RESET_POTENTIAL;
         spike     <= 1'b0;
         tick_done <= 1'b0;
         syn_ready <= 1'b0;
      end else begin
         spike     <= 1'b0;
         tick_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tick_start) begin
                  state     <= ST_INTEGRATE;
                  syn_ready <= 1'b1;
               end
            end
            ST_INTEGRATE: begin
               // syn_ready is registered high for the whole state, so
               // syn_valid alone identifies a transfer here.
               if (syn_valid) begin
                  if (!refr_active)
                     potential <= add_sat;
                  if (syn_last) begin
                     syn_ready <= 1'b0;
                     state     <= ST_LEAK;
                  end
               end
            end
            ST_LEAK: begin
               if (!refr_active)
                  potential <= leak_val;
               state <= ST_FIRE;
            end
            ST_FIRE: begin
               tick_done <= 1'b1;
               state     <= ST_IDLE;
               if (!refr_active && (potential >= THRESHOLD)) begin
                  spike     <= 1'b1;
                  potential <= RESET_POTENTIAL;
               end
            end
            default: begin
               state     <= ST_IDLE;
               syn_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef REFRACTORY_EN
   localparam int REFR_W = (REFRACTORY_TICKS > 1) ? $clog2(REFRACTORY_TICKS + 1) : 1;
   localparam logic [REFR_W-1:0] REFR_LOAD = REFR_W'(REFRACTORY_TICKS);

   logic [REFR_W-1:0] refr_cnt;

   // Counter is stable for the whole tick; it only moves in ST_FIRE, so
   // every stage of a suppressed tick sees the same refr_active.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refr_cnt <= '0;
      end else if (state == ST_FIRE) begin
         if (refr_cnt != '0)
            refr_cnt <= refr_cnt - REFR_W'(1);
         else if (potential >= THRESHOLD)
            refr_cnt <= REFR_LOAD;
      end
   end

   assign refr_active = (refr_cnt != '0);
`else
   logic unused_refr;

   // REFRACTORY_TICKS stays on the interface so both builds share one
   // parameter list; it has no effect here.
   assign unused_refr = (REFRACTORY_TICKS != 0);
   assign refr_active = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_integrator.sv
// ---------------------------------------------------------------------------
// tb_neuron_integrator
//
// Self-checking bench for neuron_integrator. Directed scenarios plus a
// randomized run compared against an integer reference model of the neuron.
// ---------------------------------------------------------------------------
module tb_neuron_integrator;

   localparam int REFR_TICKS = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               tick_start;
   logic [7:0]         synapse_in;
   logic               syn_valid;
   logic               syn_last;
   logic               syn_ready;
   logic               spike;
   logic               tick_done;
   logic signed [15:0] potential;

   int n_checks = 0;
   int n_errors = 0;

   int syn_q[$];
   int gap_max   = 2;
   bit mid_start = 0;

   int r_done_edge;
   int r_spike;
   int r_pot;
   int r_pot_pre;
   int r_ready_bad;
   int r_early_spike;
   int r_after;

   int m_pot  = 0;
   int m_refr = 0;

   neuron_integrator dut (
      .clk        (clk),
      .rst        (rst),
      .tick_start (tick_start),
      .synapse_in (synapse_in),
      .syn_valid  (syn_valid),
      .syn_last   (syn_last),
      .syn_ready  (syn_ready),
      .spike      (spike),
      .tick_done  (tick_done),
      .potential  (potential)
   );

   always #5 clk = ~clk;

   function automatic int sat16(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Reference neuron: returns 1 when the tick in syn_q should fire.
   function automatic int model_tick();
      if (m_refr > 0) begin
         m_refr--;
         return 0;
      end
      foreach (syn_q[i]) m_pot = sat16(m_pot + syn_q[i]);
      m_pot = sat16(m_pot - 1);
      if (m_pot < -16) m_pot = -16;
      if (m_pot >= 10) begin
         m_pot = 0;
`ifdef REFRACTORY_EN
         m_refr = REFR_TICKS;
`endif
         return 1;
      end
      return 0;
   endfunction

   task automatic apply_reset();
      rst        = 1'b0;
      tick_start = 1'b0;
      syn_valid  = 1'b0;
      syn_last   = 1'b0;
      synapse_in = 8'h00;
      repeat (2) @(negedge clk);
      rst    = 1'b1;
      m_pot  = 0;
      m_refr = 0;
   endtask

   // Drives one tick from syn_q and records what the DUT did afterwards.
   task automatic run_tick();
      int v;
      r_ready_bad   = 0;
      r_done_edge   = -1;
      r_spike       = -1;
      r_pot         = 0;
      r_pot_pre     = 0;
      r_early_spike = 0;
      r_after       = 0;
      @(negedge clk);
      tick_start = 1'b1;
      @(posedge clk);
      #1;
      tick_start = mid_start;
      for (int i = 0; i < syn_q.size(); i++) begin
         if (i > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
               @(posedge clk);
               #1;
            end
         end
         v          = syn_q[i];
         syn_valid  = 1'b1;
         synapse_in = v[7:0];
         syn_last   = (i == syn_q.size() - 1);
         @(negedge clk);
         if (syn_ready !== 1'b1) r_ready_bad++;
         if (syn_last) r_pot_pre = potential;
         @(posedge clk);
         #1;
         syn_valid = 1'b0;
         syn_last  = 1'b0;
      end
      tick_start = 1'b0;
      synapse_in = 8'($urandom_range(0, 255));
      for (int e = 0; e < 8; e++) begin
         @(negedge clk);
         if (r_done_edge >= 0) begin
            r_after = int'(tick_done | spike);
            break;
         end
         if (tick_done === 1'b1) begin
            r_done_edge = e;
            r_spike     = int'(spike);
            r_pot       = potential;
         end else if (spike !== 1'b0) begin
            r_early_spike = 1;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      n_checks++; if (potential !== 16'sd0) begin n_errors++; $display("FAIL reset_pot: got %0d expected 0", potential); end
      n_checks++; if (spike !== 1'b0) begin n_errors++; $display("FAIL reset_spike: got %b expected 0", spike); end
      n_checks++; if (tick_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", tick_done); end
      n_checks++; if (syn_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", syn_ready); end
      // Start a tick, feed partial sum, then pull reset asynchronously.
      tick_start = 1'b1;
      @(posedge clk);
      #1;
      tick_start = 1'b0;
      syn_valid  = 1'b1;
      synapse_in = 8'd4;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      n_checks++; if (potential !== 16'sd8) begin n_errors++; $display("FAIL midtick_pot: got %0d expected 8", potential); end
      #2;
      rst = 1'b0;
      #1;
      n_checks++; if (syn_ready !== 1'b0) begin n_errors++; $display("FAIL async_ready: got %b expected 0", syn_ready); end
      n_checks++; if (potential !== 16'sd0) begin n_errors++; $display("FAIL async_pot: got %0d expected 0", potential); end
      n_checks++; if (spike !== 1'b0) begin n_errors++; $display("FAIL async_spike: got %b expected 0", spike); end
      syn_valid = 1'b0;
      @(negedge clk);
      rst    = 1'b1;
      m_pot  = 0;
      m_refr = 0;
      // Fresh tick: 3+3-1 = 5 only if the partial 8 was discarded.
      syn_q = '{3, 3};
      run_tick();
      n_checks++; if (r_pot !== 5) begin n_errors++; $display("FAIL post_reset_pot: got %0d expected 5", r_pot); end
      n_checks++; if (r_spike !== 0) begin n_errors++; $display("FAIL post_reset_spike: got %0d expected 0", r_spike); end
   endtask

   task automatic test_fire();
      apply_reset();
      syn_q = '{4, 4, 4};
      run_tick();
      n_checks++; if (r_pot_pre !== 8) begin n_errors++; $display("FAIL fire_pre_last: got %0d expected 8", r_pot_pre); end
      n_checks++; if (r_done_edge !== 2) begin n_errors++; $display("FAIL fire_latency: got %0d expected 2", r_done_edge); end
      n_checks++; if (r_spike !== 1) begin n_errors++; $display("FAIL fire_spike: got %0d expected 1", r_spike); end
      n_checks++; if (r_pot !== 0) begin n_errors++; $display("FAIL fire_pot: got %0d expected 0", r_pot); end
      n_checks++; if (r_after !== 0) begin n_errors++; $display("FAIL fire_pulse_width: got %0d expected 0", r_after); end
      n_checks++; if (r_ready_bad !== 0) begin n_errors++; $display("FAIL fire_ready: got %0d stalls expected 0", r_ready_bad); end
      n_checks++; if (r_early_spike !== 0) begin n_errors++; $display("FAIL fire_early_spike: got %0d expected 0", r_early_spike); end
   endtask

   task automatic test_subthreshold();
      apply_reset();
      syn_q = '{3, 3};
      run_tick();
      n_checks++; if (r_pot !== 5) begin n_errors++; $display("FAIL sub_pot: got %0d expected 5", r_pot); end
      n_checks++; if (r_spike !== 0) begin n_errors++; $display("FAIL sub_spike: got %0d expected 0", r_spike); end
      n_checks++; if (r_done_edge !== 2) begin n_errors++; $display("FAIL sub_done: got %0d expected 2", r_done_edge); end
      syn_q = '{6};
      run_tick();
      n_checks++; if (r_spike !== 1) begin n_errors++; $display("FAIL sub_next_spike: got %0d expected 1", r_spike); end
      n_checks++; if (r_pot !== 0) begin n_errors++; $display("FAIL sub_next_pot: got %0d expected 0", r_pot); end
   endtask

   task automatic test_floor();
      apply_reset();
      syn_q = '{-16, -16};
      run_tick();
      n_checks++; if (r_pot_pre !== -16) begin n_errors++; $display("FAIL floor_pre_last: got %0d expected -16", r_pot_pre); end
      n_checks++; if (r_pot !== -16) begin n_errors++; $display("FAIL floor_pot: got %0d expected -16", r_pot); end
      n_checks++; if (r_spike !== 0) begin n_errors++; $display("FAIL floor_spike: got %0d expected 0", r_spike); end
   endtask

   task automatic test_ignored();
      apply_reset();
      @(negedge clk);
      syn_valid  = 1'b1;
      synapse_in = 8'd50;
      syn_last   = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (potential !== 16'sd0) begin n_errors++; $display("FAIL idle_valid_pot: got %0d expected 0", potential); end
      n_checks++; if (syn_ready !== 1'b0) begin n_errors++; $display("FAIL idle_ready: got %b expected 0", syn_ready); end
      n_checks++; if (tick_done !== 1'b0) begin n_errors++; $display("FAIL idle_done: got %b expected 0", tick_done); end
      syn_valid = 1'b0;
      syn_last  = 1'b0;
      mid_start = 1;
      syn_q = '{3, 3};
      run_tick();
      mid_start = 0;
      n_checks++; if (r_pot !== 5) begin n_errors++; $display("FAIL midstart_pot: got %0d expected 5", r_pot); end
      n_checks++; if (r_done_edge !== 2) begin n_errors++; $display("FAIL midstart_done: got %0d expected 2", r_done_edge); end
   endtask

   task automatic test_saturation();
      apply_reset();
      gap_max = 0;
      syn_q.delete();
      repeat (300) syn_q.push_back(127);
      run_tick();
      n_checks++; if (r_pot_pre !== 32767) begin n_errors++; $display("FAIL sat_max: got %0d expected 32767", r_pot_pre); end
      n_checks++; if (r_spike !== 1) begin n_errors++; $display("FAIL sat_max_spike: got %0d expected 1", r_spike); end
      apply_reset();
      syn_q.delete();
      repeat (300) syn_q.push_back(-128);
      run_tick();
      n_checks++; if (r_pot_pre !== -32768) begin n_errors++; $display("FAIL sat_min: got %0d expected -32768", r_pot_pre); end
      n_checks++; if (r_pot !== -16) begin n_errors++; $display("FAIL sat_min_floor: got %0d expected -16", r_pot); end
      gap_max = 2;
   endtask

   task automatic test_single();
      apply_reset();
      syn_q = '{12};
      run_tick();
      n_checks++; if (r_done_edge !== 2) begin n_errors++; $display("FAIL single_done: got %0d expected 2", r_done_edge); end
      n_checks++; if (r_spike !== 1) begin n_errors++; $display("FAIL single_spike: got %0d expected 1", r_spike); end
   endtask

   task automatic test_back_to_back();
      int exp_pot[3]   = '{4, 8, 0};
      int exp_spike[3] = '{0, 0, 1};
      apply_reset();
      for (int t = 0; t < 3; t++) begin
         syn_q = '{5};
         run_tick();
         n_checks++; if (r_pot !== exp_pot[t]) begin n_errors++; $display("FAIL b2b_pot[%0d]: got %0d expected %0d", t, r_pot, exp_pot[t]); end
         n_checks++; if (r_spike !== exp_spike[t]) begin n_errors++; $display("FAIL b2b_spike[%0d]: got %0d expected %0d", t, r_spike, exp_spike[t]); end
      end
   endtask

`ifdef REFRACTORY_EN
   task automatic test_refractory();
      int exp_spike[4] = '{1, 0, 0, 1};
      apply_reset();
      for (int t = 0; t < 4; t++) begin
         syn_q = '{20};
         run_tick();
         n_checks++; if (r_spike !== exp_spike[t]) begin n_errors++; $display("FAIL refr_spike[%0d]: got %0d expected %0d", t, r_spike, exp_spike[t]); end
         n_checks++; if (r_pot !== 0) begin n_errors++; $display("FAIL refr_pot[%0d]: got %0d expected 0", t, r_pot); end
         n_checks++; if (r_done_edge !== 2) begin n_errors++; $display("FAIL refr_done[%0d]: got %0d expected 2", t, r_done_edge); end
      end
   endtask
`endif

   task automatic test_random();
      int n;
      int v;
      int exp_spike;
      apply_reset();
      for (int t = 0; t < 30; t++) begin
         syn_q.delete();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) v = int'($urandom_range(0, 255)) - 128;
            else                           v = int'($urandom_range(0, 14)) - 8;
            syn_q.push_back(v);
         end
         exp_spike = model_tick();
         run_tick();
         n_checks++; if (r_spike !== exp_spike) begin n_errors++; $display("FAIL rand_spike[%0d]: got %0d expected %0d", t, r_spike, exp_spike); end
         n_checks++; if (r_pot !== m_pot) begin n_errors++; $display("FAIL rand_pot[%0d]: got %0d expected %0d", t, r_pot, m_pot); end
         n_checks++; if (r_done_edge !== 2) begin n_errors++; $display("FAIL rand_done[%0d]: got %0d expected 2", t, r_done_edge); end
      end
   endtask

   initial begin
      rst        = 1'b0;
      tick_start = 1'b0;
      syn_valid  = 1'b0;
      syn_last   = 1'b0;
      synapse_in = 8'h00;
      test_reset();
      test_fire();
      test_subthreshold();
      test_floor();
      test_ignored();
      test_saturation();
      test_single();
      test_back_to_back();
`ifdef REFRACTORY_EN
      test_refractory();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "time limit");
   end

endmodule
